// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of every signal between the two-port memory arbiter and its
// surroundings: the instruction-fetch port (i_*), the data port (d_*), the
// single-port memory (mem_*) and the conflict statistics counter.
//
// Modports
//   slave  : the arbiter itself (consumes requests and memory read data,
//            produces grants, responses and the memory strobe).
//   master : the environment (requesters and memory model).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 12
);
    // instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    // data port
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_we;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    // memory side
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    // statistics
    logic [15:0]       conflict_cnt;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a data
// port. Grants are combinational (same cycle as the request); when both ports
// request, the one not served last wins (strict alternation under constant
// contention). Reads are tracked by a MEM_LAT-deep tag pipeline so that each
// memory response is captured into the owning port's rdata register and
// flagged with a one-cycle rvalid, in grant order.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_arbiter_if.slave -- request ports, memory port, conflict_cnt
//
// Parameters
//   ADDR_W  : word-address width
//   MEM_LAT : memory read latency in cycles (1..4)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    // ---------------------------------------------------------------- grant
    logic              last_d_reg;     // 0: fetch port served last, 1: data port
    logic              grant_i;
    logic              grant_d;
    logic [ADDR_W-1:0] addr_sel;
    logic [3:0]        we_sel;
    logic [31:0]       wdata_sel;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (bus.i_req && bus.d_req) begin
                // contention: serve whichever port did not win last time
                grant_d = !last_d_reg;
                grant_i = last_d_reg;
            end else begin
                grant_i = bus.i_req;
                grant_d = bus.d_req;
            end
        end
    end

    always_comb begin
        addr_sel  = bus.i_addr;
        we_sel    = 4'b0000;
        wdata_sel = 32'h0;
        if (grant_d) begin
            addr_sel  = bus.d_addr;
            we_sel    = bus.d_we;
            wdata_sel = bus.d_wdata;
        end
    end

    assign bus.i_gnt     = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.mem_en    = grant_i | grant_d;
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_reg <= 1'b0;
        end else if (grant_d) begin
            last_d_reg <= 1'b1;
        end else if (grant_i) begin
            last_d_reg <= 1'b0;
        end
    end

    // --------------------------------------------------------- tag pipeline
    // Stage k holds the tag of the access granted k+1 cycles ago; the last
    // stage lines up with the cycle in which mem_rdata carries that data.
    logic [MEM_LAT-1:0] tag_valid_reg;
    logic [MEM_LAT-1:0] tag_owner_reg;     // 1: data port, 0: fetch port
    logic               tag_valid_next;

    // writes occupy the memory but never produce a response
    assign tag_valid_next = grant_i | (grant_d && (bus.d_we == 4'b0000));

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg[0] <= 1'b0;
            tag_owner_reg[0] <= 1'b0;
        end else begin
            tag_valid_reg[0] <= tag_valid_next;
            tag_owner_reg[0] <= grant_d;
        end
    end

    for (genvar gi = 1; gi < MEM_LAT; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_valid_reg[gi] <= 1'b0;
                tag_owner_reg[gi] <= 1'b0;
            end else begin
                tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                tag_owner_reg[gi] <= tag_owner_reg[gi-1];
            end
        end
    end

    // ------------------------------------------------------------ responses
    logic        i_rvalid_reg;
    logic        d_rvalid_reg;
    logic [31:0] i_rdata_reg;
    logic [31:0] d_rdata_reg;
    logic        rsp_i;
    logic        rsp_d;

    assign rsp_i = tag_valid_reg[MEM_LAT-1] && !tag_owner_reg[MEM_LAT-1];
    assign rsp_d = tag_valid_reg[MEM_LAT-1] &&  tag_owner_reg[MEM_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            i_rdata_reg  <= 32'h0;
            d_rdata_reg  <= 32'h0;
        end else begin
            i_rvalid_reg <= rsp_i;
            d_rvalid_reg <= rsp_d;
            // the port not being answered keeps its last data
            if (rsp_i) begin
                i_rdata_reg <= bus.mem_rdata;
            end
            if (rsp_d) begin
                d_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    assign bus.i_rvalid = i_rvalid_reg;
    assign bus.d_rvalid = d_rvalid_reg;
    assign bus.i_rdata  = i_rdata_reg;
    assign bus.d_rdata  = d_rdata_reg;

    // ------------------------------------------------------ conflict counter
    // counts cycles where both ports want the memory, regardless of who wins
    logic [15:0] conflict_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_reg <= 16'h0;
        end else if (bus.i_req && bus.d_req && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign bus.conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances (MEM_LAT = 1 and MEM_LAT = 3) receive the same request
// stream. Each has its own memory model and its own reference model: the
// model decides the grant from the round-robin rule, keeps a shadow copy of
// memory, and holds a queue of expected read responses stamped with the cycle
// in which rvalid must appear.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W = 12;

    typedef struct {
        int          due;
        bit          is_d;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_we;
    logic [31:0]       d_wdata;

    logic i_gnt_w [2];
    logic d_gnt_w [2];
    bit   verbose = 1'b1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // power-on memory contents; address 0x010 holds a known instruction word
    function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
        if (a == 12'h010) return 32'h2402000A;
        return 32'h5A00_0000 + 32'(a) * 32'h0001_0003;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_lat
        localparam int LAT = (gi == 0) ? 1 : 3;

        mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

        mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.i_req   = i_req;
        assign bus.i_addr  = i_addr;
        assign bus.d_req   = d_req;
        assign bus.d_addr  = d_addr;
        assign bus.d_we    = d_we;
        assign bus.d_wdata = d_wdata;
        assign i_gnt_w[gi] = bus.i_gnt;
        assign d_gnt_w[gi] = bus.d_gnt;

        // memory model: stored as XOR against init_word so it needs no preload
        bit   [31:0] mem_delta [1<<ADDR_W];
        logic [31:0] rd_pipe   [LAT];
        assign bus.mem_rdata = rd_pipe[LAT-1];

        always @(posedge clk) begin
            rd_pipe[0] <= bus.mem_en ? (mem_delta[bus.mem_addr] ^ init_word(bus.mem_addr))
                                     : 32'($urandom);
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (bus.mem_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_we[b])
                        mem_delta[bus.mem_addr][8*b +: 8] <=
                            bus.mem_wdata[8*b +: 8] ^ init_word(bus.mem_addr)[8*b +: 8];
                end
            end
        end

        // reference model
        logic [31:0] shadow [int];
        resp_t       pend [$];

        function automatic logic [31:0] shadow_rd(input logic [ADDR_W-1:0] a);
            return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
        endfunction

        initial begin : model
            resp_t       r;
            string       pfx;
            bit          last_d, armed, gi_e, gd_e, iv_e, dv_e;
            int          cnt, cyc;
            logic [31:0] ird_e, drd_e, w;
            pfx = (LAT == 1) ? "lat1" : "lat3";
            last_d = 1'b0; armed = 1'b0; cnt = 0; cyc = 0; ird_e = 0; drd_e = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    check_val({pfx, ".rst_i_gnt"}, 32'(bus.i_gnt), 32'h0);
                    check_val({pfx, ".rst_d_gnt"}, 32'(bus.d_gnt), 32'h0);
                    check_val({pfx, ".rst_mem_en"}, 32'(bus.mem_en), 32'h0);
                    check_val({pfx, ".rst_mem_we"}, 32'(bus.mem_we), 32'h0);
                    pend.delete();
                    last_d = 1'b0; cnt = 0; ird_e = 0; drd_e = 0; armed = 1'b1;
                end else if (armed) begin
                    // responses due this cycle
                    iv_e = 1'b0; dv_e = 1'b0;
                    if (pend.size() > 0 && pend[0].due == cyc) begin
                        r = pend.pop_front();
                        if (r.is_d) begin dv_e = 1'b1; drd_e = r.data; end
                        else        begin iv_e = 1'b1; ird_e = r.data; end
                        if (verbose)
                            $display("txn %s response port=%s data=%h", pfx, r.is_d ? "D" : "I", r.data);
                    end
                    check_val({pfx, ".i_rvalid"}, 32'(bus.i_rvalid), 32'(iv_e));
                    check_val({pfx, ".d_rvalid"}, 32'(bus.d_rvalid), 32'(dv_e));
                    check_val({pfx, ".i_rdata"}, bus.i_rdata, ird_e);
                    check_val({pfx, ".d_rdata"}, bus.d_rdata, drd_e);
                    check_val({pfx, ".conflict_cnt"}, 32'(bus.conflict_cnt), 32'(cnt));

                    // who should be granted this cycle
                    if (i_req && d_req) begin gd_e = !last_d; gi_e = last_d; end
                    else                begin gi_e = i_req;   gd_e = d_req;  end
                    check_val({pfx, ".i_gnt"}, 32'(bus.i_gnt), 32'(gi_e));
                    check_val({pfx, ".d_gnt"}, 32'(bus.d_gnt), 32'(gd_e));
                    check_val({pfx, ".mem_en"}, 32'(bus.mem_en), 32'(gi_e | gd_e));
                    if (gi_e) begin
                        check_val({pfx, ".mem_addr_i"}, 32'(bus.mem_addr), 32'(i_addr));
                        check_val({pfx, ".mem_we_i"}, 32'(bus.mem_we), 32'h0);
                        check_val({pfx, ".mem_wdata_i"}, bus.mem_wdata, 32'h0);
                    end else if (gd_e) begin
                        check_val({pfx, ".mem_addr_d"}, 32'(bus.mem_addr), 32'(d_addr));
                        check_val({pfx, ".mem_we_d"}, 32'(bus.mem_we), 32'(d_we));
                        check_val({pfx, ".mem_wdata_d"}, bus.mem_wdata, d_wdata);
                    end else begin
                        check_val({pfx, ".mem_we_idle"}, 32'(bus.mem_we), 32'h0);
                    end

                    // state advance for the coming edge
                    if (i_req && d_req && cnt < 65535) cnt++;
                    if (gi_e) begin
                        pend.push_back('{cyc + LAT + 1, 1'b0, shadow_rd(i_addr)});
                        last_d = 1'b0;
                    end
                    if (gd_e) begin
                        if (d_we == 4'b0000) begin
                            pend.push_back('{cyc + LAT + 1, 1'b1, shadow_rd(d_addr)});
                        end else begin
                            w = shadow_rd(d_addr);
                            for (int b = 0; b < 4; b++)
                                if (d_we[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                            shadow[int'(d_addr)] = w;
                        end
                        last_d = 1'b1;
                    end
                end
                cyc++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one randomized cycle; a pending request stays stable until granted
    task automatic drive_cycle(input int pi, input int pd, input int pw, input int amax);
        bit ig, dg;
        @(negedge clk);
        ig = i_gnt_w[0];
        dg = d_gnt_w[0];
        @(posedge clk);
        #1;
        rst = ($urandom_range(199) == 0);
        if (!i_req || ig) begin
            i_req  = ($urandom_range(99) < pi);
            i_addr = ADDR_W'($urandom_range(amax));
        end
        if (!d_req || dg) begin
            d_req   = ($urandom_range(99) < pd);
            d_addr  = ADDR_W'($urandom_range(amax));
            d_we    = ($urandom_range(99) < pw) ? 4'($urandom_range(15)) : 4'h0;
            d_wdata = 32'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
        d_we = 4'h0; d_wdata = 32'h0;
        step(2);
        rst = 1'b0;

        $display("txn fetch read 0x010");
        i_req = 1'b1; i_addr = 12'h010;
        step(1);
        i_req = 1'b0;
        step(5);

        $display("txn reset then 6 cycles of contention");
        rst = 1'b1; step(1); rst = 1'b0;
        i_req = 1'b1; i_addr = 12'h020; d_req = 1'b1; d_addr = 12'h021; d_we = 4'h0;
        step(6);
        i_req = 1'b0; d_req = 1'b0;
        step(5);

        $display("txn data write mask 0011 to 0x004, then read back");
        d_req = 1'b1; d_addr = 12'h004; d_we = 4'b0011; d_wdata = 32'hDEADBEEF;
        step(1);
        d_we = 4'b0000;
        step(1);
        d_req = 1'b0;
        step(5);

        $display("txn reads I@1 D@2 I@3 back to back");
        i_req = 1'b1; i_addr = 12'h001; step(1);
        i_req = 1'b0; d_req = 1'b1; d_addr = 12'h002; step(1);
        d_req = 1'b0; i_req = 1'b1; i_addr = 12'h003; step(1);
        i_req = 1'b0;
        step(6);

        $display("txn read then reset one cycle later");
        i_req = 1'b1; i_addr = 12'h005; step(1);
        i_req = 1'b0; rst = 1'b1; step(1);
        rst = 1'b0;
        step(6);

        $display("txn random traffic");
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) drive_cycle(60, 60, 40, 31);
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
        step(1);
        rst = 1'b0;

        $display("txn 65540 contention cycles for counter saturation");
        i_req = 1'b1; d_req = 1'b1; i_addr = 12'h007; d_addr = 12'h008;
        step(65540);
        i_req = 1'b0; d_req = 1'b0;
        step(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width.
REQ-002 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch read request.
REQ-006 i_addr  input  ADDR_W  fetch word address.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid  output  1  i_rdata valid this cycle.
REQ-009 i_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_addr  input  ADDR_W  data word address.
REQ-012 d_we  input  4  byte write mask; 4'b0000 means read.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  d_rdata valid this cycle.
REQ-016 d_rdata  output  32  load read data.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  4  memory byte write enables.
REQ-019 mem_addr  output  ADDR_W  memory word address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  memory read data, valid MEM_LAT cycles after mem_en.
REQ-022 conflict_cnt  output  16  count of cycles with i_req and d_req both high.

Function
REQ-023 Requester holds req/addr/we/wdata stable until its gnt is high; gnt high consumes the request that cycle.
REQ-024 At most one gnt per cycle; gnt asserted combinationally in the same cycle as req when granted.
REQ-025 Single requester: granted immediately, no idle bubble, back-to-back grants every cycle.
REQ-026 Both requesting: round-robin; grant the port not in register last_srv; last_srv updates to the granted port on every grant.
REQ-027 In a granted cycle mem_en=1 and mem_addr/mem_we/mem_wdata come from the granted port; fetch forces mem_we=4'b0000, mem_wdata=0.
REQ-028 No grant: mem_en=0, mem_we=0; mem_addr/mem_wdata don't-care.
REQ-029 Tag pipeline, depth MEM_LAT, entries {valid, owner}; valid set only for reads (fetch, or data with d_we=0).
REQ-030 Read granted at cycle T: x_rdata registered from mem_rdata at T+MEM_LAT, x_rvalid=1 for exactly one cycle at T+MEM_LAT+1.
REQ-031 Writes never produce rvalid; a write granted at T and a read at T+1 are both legal.
REQ-032 Up to MEM_LAT+1 reads outstanding; responses return in grant order, routed only by owner tag.
REQ-033 rdata of the non-selected port holds its previous value.
REQ-034 conflict_cnt increments by 1 on each cycle with i_req=1 and d_req=1; saturates at 16'hFFFF, no wrap.
REQ-035 Fairness: with both ports continuously requesting, grants alternate strictly (I,D,I,D or D,I,D,I).

Reset
REQ-036 While rst=1: i_gnt=0, d_gnt=0, mem_en=0, mem_we=0; requests ignored.
REQ-037 After the rst edge: i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, conflict_cnt=0, last_srv=I, all tag entries invalid.
REQ-038 Reset mid-operation: in-flight reads discarded; no rvalid in any cycle after a rst edge until a new read is granted.
REQ-039 First conflict after reset grants D (last_srv=I).

Verification
REQ-040 MEM_LAT=1; i_req only, i_addr=0x010, mem returns 0x2402000A -> i_gnt same cycle, i_rvalid at T+2, i_rdata=0x2402000A.
REQ-041 Both req held 6 cycles after reset -> grants D,I,D,I,D,I; conflict_cnt=6 (counts requester overlap, not wins).
REQ-042 d_we=4'b0011, d_wdata=0xDEADBEEF, d_addr=0x004 -> mem_we=0011, mem_wdata=0xDEADBEEF, no d_rvalid ever.
REQ-043 MEM_LAT=3; reads I@0x1, D@0x2, I@0x3 on consecutive cycles -> rvalids in order I,D,I on consecutive cycles with matching data.
REQ-044 rst pulsed one cycle after a read grant -> no rvalid follows; all outputs at reset values.
REQ-045 Preload conflict_cnt near 16'hFFFF by 65540 conflict cycles -> holds 16'hFFFF.
